// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: command sequencer for one tiny_dnn_core and its normalize stage.
// LOAD streams N weights plus a bias word into the core weight RAM. RUN performs
// an N-term dot product plus bias, pulses normalize, and offers the fp32 result
// on a valid/ready handshake. It also drives the external d-buffer read port.
module tiny_dnn_seq #(
  parameter int F_SIZE = 1024,
  parameter int AW     = $clog2(F_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cfg_len,
  input  logic          start_load,
  input  logic          start_run,
  output logic          busy,
  output logic          load_done,
  input  logic          w_valid,
  input  logic [15:0]   w_data,
  output logic          w_ready,
  output logic          core_init,
  output logic          core_write,
  output logic          core_bwrite,
  output logic [AW-1:0] core_wa,
  output logic [15:0]   core_wd,
  output logic          core_exec,
  output logic          core_bias,
  output logic [AW-1:0] core_ra,
  output logic          d_rd,
  output logic [AW-1:0] d_addr,
  output logic          norm_en,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    MAC,
    BIAS,
    DRAIN,
    NORM,
    OUT
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] len;
  logic          beat;
  logic          last_beat;

  // A weight beat is accepted whenever LOAD sees w_valid; the beat with
  // cnt==len carries the bias word. The core steers bwrite beats to its
  // reserved bias entry (F_SIZE-1), so core_wa simply follows the counter.
  assign beat        = (state == LOAD) && w_valid;
  assign last_beat   = beat && (cnt == len);
  assign core_write  = beat;
  assign core_bwrite = last_beat;
  assign core_wa     = beat ? cnt : '0;
  assign core_wd     = w_data;

  // The d buffer is read in lockstep with the core weight read, so its
  // 1-cycle latency lines d up with the weight coming out of the core RAM.
  assign d_rd   = core_exec;
  assign d_addr = core_ra;

  // Single state machine; every non-beat output is a registered decode of the
  // state being entered, so it is valid for the whole cycle of that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      w_ready   <= 1'b0;
      core_init <= 1'b0;
      core_exec <= 1'b0;
      core_bias <= 1'b0;
      core_ra   <= '0;
      norm_en   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      core_init <= 1'b0;
      core_bias <= 1'b0;
      norm_en   <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_load) begin
            len     <= cfg_len;
            cnt     <= '0;
            busy    <= 1'b1;
            w_ready <= 1'b1;
            state   <= LOAD;
          end else if (start_run) begin
            len       <= cfg_len;
            cnt       <= '0;
            busy      <= 1'b1;
            core_init <= 1'b1;
            state     <= INIT;
          end
        end
        LOAD: begin
          if (last_beat) begin
            cnt       <= '0;
            busy      <= 1'b0;
            w_ready   <= 1'b0;
            load_done <= 1'b1;
            state     <= IDLE;
          end else if (beat) begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT: begin
          if (len != '0) begin
            cnt       <= '0;
            core_ra   <= '0;
            core_exec <= 1'b1;
            state     <= MAC;
          end else begin
            core_bias <= 1'b1;
            state     <= BIAS;
          end
        end
        MAC: begin
          if (cnt == len - 1'b1) begin
            cnt       <= '0;
            core_ra   <= '0;
            core_exec <= 1'b0;
            core_bias <= 1'b1;
            state     <= BIAS;
          end else begin
            cnt     <= cnt + 1'b1;
            core_ra <= cnt + 1'b1;
          end
        end
        BIAS: begin
          state <= DRAIN;
        end
        DRAIN: begin
          norm_en <= 1'b1;
          state   <= NORM;
        end
        NORM: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// tb_tiny_dnn_seq: directed bench for tiny_dnn_seq. A small behavioural model of
// the core RAM/accumulator, d buffer and normalize stage is driven purely by the
// DUT outputs; results are compared against hand-computed constants.
module tb_tiny_dnn_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  cfg_len = '0;
  logic        start_load = 1'b0;
  logic        start_run = 1'b0;
  logic        busy;
  logic        load_done;
  logic        w_valid = 1'b0;
  logic [15:0] w_data = '0;
  logic        w_ready;
  logic        core_init;
  logic        core_write;
  logic        core_bwrite;
  logic [9:0]  core_wa;
  logic [15:0] core_wd;
  logic        core_exec;
  logic        core_bias;
  logic [9:0]  core_ra;
  logic        d_rd;
  logic [9:0]  d_addr;
  logic        norm_en;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  tiny_dnn_seq #(.F_SIZE(1024), .AW(10)) dut (
    .clk(clk), .reset(reset), .cfg_len(cfg_len),
    .start_load(start_load), .start_run(start_run),
    .busy(busy), .load_done(load_done),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .core_init(core_init), .core_write(core_write), .core_bwrite(core_bwrite),
    .core_wa(core_wa), .core_wd(core_wd), .core_exec(core_exec),
    .core_bias(core_bias), .core_ra(core_ra), .d_rd(d_rd), .d_addr(d_addr),
    .norm_en(norm_en), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [39:0] all_outs;
  assign all_outs = {busy, load_done, w_ready, core_init, core_write, core_bwrite,
                     core_exec, core_bias, norm_en, out_valid, core_wa, core_ra, d_addr};

  // bf16 and fp32 <-> real helpers for the accumulator model
  function automatic real bf16_to_real(input logic [15:0] b);
    logic [63:0] d;
    if (b[14:0] == 15'd0) return 0.0;
    d = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Core / d-buffer / normalize model plus event counters
  logic [15:0] wmem [1024];
  logic [15:0] dbuf [1024];
  real         acc = 0.0;
  logic [31:0] nrm_model = '0;
  bit          exec_q = 0, bias_q = 0, prev_exec = 0;
  logic [9:0]  ra_q = '0;
  logic [15:0] d_q = '0;
  int write_cnt = 0, bwrite_cnt = 0, done_cnt = 0, exec_cnt = 0, init_cnt = 0;
  int viol = 0, first_kind = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 16'h0000;
      dbuf[i] = 16'h3f80;
    end
  end

  always @(posedge clk) begin
    if (exec_q) acc = acc + bf16_to_real(wmem[ra_q]) * bf16_to_real(d_q);
    if (bias_q) acc = acc + bf16_to_real(wmem[1023]);
    if (core_init) acc = 0.0;
    if (norm_en) nrm_model = real_to_fp32(acc);
    exec_q = core_exec;
    ra_q   = core_ra;
    bias_q = core_bias;
    if (d_rd) d_q = dbuf[d_addr];
    if (core_bwrite) wmem[1023] = core_wd;
    else if (core_write) wmem[core_wa] = core_wd;
    if (core_write) write_cnt++;
    if (core_bwrite) bwrite_cnt++;
    if (load_done) done_cnt++;
    if (core_exec) exec_cnt++;
    if (core_init) init_cnt++;
    if (core_init && (core_exec || prev_exec)) viol++;
    prev_exec = core_exec;
    if (reset) first_kind = 0;
    else if (first_kind == 0 && core_init) first_kind = 1;
    else if (first_kind == 0 && core_exec) first_kind = 2;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LOAD command: n+1 beats (weights then bias), optionally gapped
  task automatic applyStimulus(input logic [9:0] n, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3,
                               input bit gap, input bit with_run);
    logic [15:0] words [4];
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    @(negedge clk);
    cfg_len = n; start_load = 1'b1; start_run = with_run;
    @(negedge clk);
    start_load = 1'b0; start_run = 1'b0;
    for (int i = 0; i <= int'(n); i++) begin
      w_valid = 1'b1; w_data = words[i];
      @(negedge clk);
      w_valid = 1'b0;
      if (gap) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  // RUN command with latency, result, exec-count checks and optional stall
  task automatic runCommand(input string tag, input logic [9:0] n, input logic [31:0] exp_nrm,
                            input int exp_lat, input int hold);
    int lat, e0, i0;
    bit stable;
    logic [31:0] held;
    e0 = exec_cnt; lat = -1;
    @(negedge clk);
    cfg_len = n; start_run = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      start_run = 1'b0;
      if (out_valid) begin lat = k; break; end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_nrm"}, 64'(nrm_model), 64'(exp_nrm));
    checkOutput({tag, "_exec_pulses"}, 64'(exec_cnt - e0), 64'(n));
    i0 = init_cnt;
    if (hold > 0) begin
      stable = 1; held = nrm_model;
      for (int h = 0; h < hold; h++) begin
        start_run = (h == 3);
        @(negedge clk);
        if (!out_valid || !busy || nrm_model != held) stable = 0;
      end
      start_run = 1'b0;
      checkOutput({tag, "_hold_stable"}, 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, {62'd0, out_valid, busy}, 64'd0);
    @(negedge clk);
    checkOutput({tag, "_no_new_run"}, {32'(init_cnt - i0), 31'd0, busy}, 64'd0);
  endtask

  initial begin
    int w0, b0, d0, i0;
    bit found;

    // reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 64'(all_outs), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: LOAD N=3, gapped beats
    w0 = write_cnt; b0 = bwrite_cnt; d0 = done_cnt;
    applyStimulus(10'd3, 16'h3f80, 16'h4000, 16'h4040, 16'h3f80, 1'b1, 1'b0);
    checkOutput("t1_writes", 64'(write_cnt - w0), 64'd4);
    checkOutput("t1_bwrites", 64'(bwrite_cnt - b0), 64'd1);
    checkOutput("t1_load_done", 64'(done_cnt - d0), 64'd1);
    checkOutput("t1_w2", 64'(wmem[2]), 64'h4040);
    checkOutput("t1_bias", 64'(wmem[1023]), 64'h3f80);
    checkOutput("t1_idle", {62'd0, busy, w_ready}, 64'd0);

    // 2: RUN N=3, d all 1.0 -> 1+2+3+1 = 7.0
    runCommand("t2", 10'd3, 32'h40e00000, 8, 0);

    // 3: LOAD bias 2.0 only, then RUN N=0 -> 2.0
    w0 = write_cnt; b0 = bwrite_cnt;
    applyStimulus(10'd0, 16'h4000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("t3_bias_only_writes", {32'(write_cnt - w0), 32'(bwrite_cnt - b0)}, {32'd1, 32'd1});
    checkOutput("t3_w0_kept", 64'(wmem[0]), 64'h3f80);
    runCommand("t3", 10'd0, 32'h40000000, 5, 0);

    // 4: RUN N=3 with out_ready stalled 10 cycles -> 8.0
    runCommand("t4", 10'd3, 32'h41000000, 8, 10);

    // 5: reset in MAC at cnt=5 of N=16, then RUN N=2 -> 1+2+2 = 5.0
    found = 0;
    @(negedge clk);
    cfg_len = 10'd16; start_run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_run = 1'b0;
      if (core_exec && core_ra == 10'd5) begin found = 1; break; end
    end
    checkOutput("t5_reached_cnt5", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5_async_clear", 64'(all_outs), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    runCommand("t5", 10'd2, 32'h40a00000, 7, 0);
    checkOutput("t5_init_first", 64'(first_kind), 64'd1);

    // 6: start_load and start_run together -> LOAD only
    d0 = done_cnt; i0 = init_cnt; b0 = bwrite_cnt;
    applyStimulus(10'd0, 16'h3f80, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("t6_load_done", 64'(done_cnt - d0), 64'd1);
    checkOutput("t6_run_dropped", 64'(init_cnt - i0), 64'd0);
    checkOutput("t6_bwrite", 64'(bwrite_cnt - b0), 64'd1);
    checkOutput("t6_idle", 64'(busy), 64'd0);

    checkOutput("exec_init_order", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
